// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX operand forwarding selects plus load-use stall/bubble control for IF/ID.
// Define FORWARD_EN to enable bypass forwarding; otherwise every RAW dependence interlocks.

`ifndef FORWARD_NO_COLLISION
`define FORWARD_NO_COLLISION     3'b001
`endif
`ifndef FORWARD_COLLISION_IN_MEM
`define FORWARD_COLLISION_IN_MEM 3'b010
`endif
`ifndef FORWARD_COLLISION_IN_WB
`define FORWARD_COLLISION_IN_WB  3'b100
`endif

// One operand's view of the shadow pipeline: EX forward select and ID-side hazard.
module forward_hazard_lane #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rs_id,
    input  logic                      use_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
    input  logic                      we_ex,
    input  logic                      ld_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rd_mem,
    input  logic                      we_mem,
    input  logic [REG_ADDR_WIDTH-1:0] rd_wb,
    input  logic                      we_wb,
    output logic [2:0]                fwd_sel,
    output logic                      hazard
);
    logic dep_ex;

    assign dep_ex = use_id && (rd_ex != '0) && (rd_ex == rs_id);

`ifdef FORWARD_EN
    logic hit_mem;
    logic hit_wb;
    logic unused_lane;

    assign hit_mem = we_mem && (rd_mem != '0) && (rd_mem == rs_ex);
    assign hit_wb  = we_wb  && (rd_wb  != '0) && (rd_wb  == rs_ex);

    // MEM wins over WB: it holds the younger writer of the same register.
    always_comb begin
        fwd_sel = `FORWARD_NO_COLLISION;
        if (hit_mem)
            fwd_sel = `FORWARD_COLLISION_IN_MEM;
        else if (hit_wb)
            fwd_sel = `FORWARD_COLLISION_IN_WB;
    end

    // Only a load in EX cannot be bypassed in time.
    assign hazard      = ld_ex && dep_ex;
    assign unused_lane = we_ex;
`else
    logic dep_mem;
    logic dep_wb;
    logic unused_lane;

    assign dep_mem = use_id && (rd_mem != '0) && (rd_mem == rs_id);
    assign dep_wb  = use_id && (rd_wb  != '0) && (rd_wb  == rs_id);

    assign fwd_sel     = `FORWARD_NO_COLLISION;
    // No bypass and no write-through: wait until the writer has left MEM/WB.
    assign hazard      = (we_ex && dep_ex) || (we_mem && dep_mem) || (we_wb && dep_wb);
    assign unused_lane = ^{rs_ex, ld_ex};
`endif
endmodule

module forward_hazard_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
    input  logic                      reg_write_ID,
    input  logic                      mem_read_ID,
    input  logic                      use_rs1_ID,
    input  logic                      use_rs2_ID,
    input  logic                      flush_ID_EX,
    input  logic                      hold,
    output logic [2:0]                forward_detect_EX_rs1,
    output logic [2:0]                forward_detect_EX_rs2,
    output logic                      stall_IF,
    output logic                      stall_ID,
    output logic                      bubble_ID_EX
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      ld;
    } id_ex_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      ld;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
    } mem_wb_t;

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] rs_ex_v;
    logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] rs_id_v;
    logic [NUM_OPS-1:0]                     use_id_v;
    logic [NUM_OPS-1:0][2:0]                fwd_v;
    logic [NUM_OPS-1:0]                     hz_v;
    logic                                   hazard;

    logic [DATA_WIDTH-1:0] unused_dw;
    logic                  unused_top;

    assign unused_dw  = '0;
    assign unused_top = ex_mem_q.ld;

    assign rs_ex_v  = {id_ex_q.rs2, id_ex_q.rs1};
    assign rs_id_v  = {rs2_ID, rs1_ID};
    assign use_id_v = {use_rs2_ID, use_rs1_ID};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_lane
        forward_hazard_lane #(
            .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
        ) u_lane (
            .rs_ex  (rs_ex_v[g]),
            .rs_id  (rs_id_v[g]),
            .use_id (use_id_v[g]),
            .rd_ex  (id_ex_q.rd),
            .we_ex  (id_ex_q.we),
            .ld_ex  (id_ex_q.ld),
            .rd_mem (ex_mem_q.rd),
            .we_mem (ex_mem_q.we),
            .rd_wb  (mem_wb_q.rd),
            .we_wb  (mem_wb_q.we),
            .fwd_sel(fwd_v[g]),
            .hazard (hz_v[g])
        );
    end

    assign hazard                = |hz_v;
    assign forward_detect_EX_rs1 = fwd_v[0];
    assign forward_detect_EX_rs2 = fwd_v[1];

    // A flushed slot is wrong-path, so its stall is dropped but the bubble stays.
    assign stall_IF     = hazard && !flush_ID_EX;
    assign stall_ID     = hazard && !flush_ID_EX;
    assign bubble_ID_EX = hazard || flush_ID_EX;

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (!hold) begin
            if (bubble_ID_EX) begin
                id_ex_d = '0;
            end else begin
                id_ex_d.rs1 = rs1_ID;
                id_ex_d.rs2 = rs2_ID;
                id_ex_d.rd  = rd_ID;
                id_ex_d.we  = reg_write_ID;
                id_ex_d.ld  = mem_read_ID;
            end
            ex_mem_d.rd = id_ex_q.rd;
            ex_mem_d.we = id_ex_q.we;
            ex_mem_d.ld = id_ex_q.ld;
            mem_wb_d.rd = ex_mem_q.rd;
            mem_wb_d.we = ex_mem_q.we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed hazard scenarios then random traffic vs an age-list model.
// Honours FORWARD_EN the same way the design does.

`timescale 1ns/1ps

`ifndef FORWARD_NO_COLLISION
`define FORWARD_NO_COLLISION     3'b001
`endif
`ifndef FORWARD_COLLISION_IN_MEM
`define FORWARD_COLLISION_IN_MEM 3'b010
`endif
`ifndef FORWARD_COLLISION_IN_WB
`define FORWARD_COLLISION_IN_WB  3'b100
`endif

module tb_forward_hazard_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic       reg_write_ID, mem_read_ID, use_rs1_ID, use_rs2_ID, flush_ID_EX, hold;
    logic [2:0] f1, f2;
    logic       stall_IF, stall_ID, bubble_ID_EX;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .reg_write_ID(reg_write_ID), .mem_read_ID(mem_read_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .flush_ID_EX(flush_ID_EX), .hold(hold),
        .forward_detect_EX_rs1(f1), .forward_detect_EX_rs2(f2),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_ID_EX(bubble_ID_EX)
    );

    // Age list of in-flight instructions: older[d] entered the pipe d+1 edges ago.
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       we, ld;
    } ins_t;
    ins_t older[3];

`ifdef FORWARD_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    function automatic bit id_reads(input logic [4:0] r);
        return (r != 0) && ((use_rs1_ID && rs1_ID == r) || (use_rs2_ID && rs2_ID == r));
    endfunction

    // Newest older writer (distance 1 or 2 from EX) supplies the operand.
    function automatic logic [2:0] m_code(input logic [4:0] rs);
        if (!FE) return `FORWARD_NO_COLLISION;
        for (int d = 1; d < 3; d++)
            if (older[d].we && older[d].rd != 0 && older[d].rd == rs)
                return (d == 1) ? `FORWARD_COLLISION_IN_MEM : `FORWARD_COLLISION_IN_WB;
        return `FORWARD_NO_COLLISION;
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        if (FE) begin
            h = older[0].ld && id_reads(older[0].rd);
        end else begin
            for (int d = 0; d < 3; d++)
                if (older[d].we && id_reads(older[d].rd)) h = 1;
        end
        return h;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag);
        bit h;
        h = m_hazard();
        cmp({tag, ".rs1code"}, {5'd0, f1}, {5'd0, m_code(older[0].rs1)});
        cmp({tag, ".rs2code"}, {5'd0, f2}, {5'd0, m_code(older[0].rs2)});
        cmp({tag, ".stall_IF"}, {7'd0, stall_IF}, {7'd0, h && !flush_ID_EX});
        cmp({tag, ".stall_ID"}, {7'd0, stall_ID}, {7'd0, h && !flush_ID_EX});
        cmp({tag, ".bubble"}, {7'd0, bubble_ID_EX}, {7'd0, h || flush_ID_EX});
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) older[d] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    endtask

    task automatic tick();
        bit b;
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (!hold) begin
            b = m_hazard() || flush_ID_EX;
            older[2] = older[1];
            older[1] = older[0];
            if (b) older[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
            else   older[0] = '{rs1_ID, rs2_ID, rd_ID, reg_write_ID, mem_read_ID};
        end
        #1;
    endtask

    task automatic set_id(input logic [4:0] a, b, d, input logic we, ld, u1, u2);
        rs1_ID = a; rs2_ID = b; rd_ID = d;
        reg_write_ID = we; mem_read_ID = ld; use_rs1_ID = u1; use_rs2_ID = u2;
    endtask

    // Present an instruction in ID until it is accepted; returns stall cycles seen on the DUT.
    task automatic issue(input logic [4:0] a, b, d, input logic we, ld, u1, u2,
                         input string tag, output int nst);
        set_id(a, b, d, we, ld, u1, u2);
        flush_ID_EX = 0; hold = 0; nst = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk(tag);
            if (stall_ID) nst++;
            if (!m_hazard()) begin
                tick();
                return;
            end
            tick();
        end
        cmp({tag, ".accept_timeout"}, 8'd1, 8'd0);
    endtask

    task automatic nop_check(input string tag, input logic [2:0] e1);
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        cmp({tag, ".code"}, {5'd0, f1}, {5'd0, e1});
        chk(tag);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; flush_ID_EX = 0; hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        cmp("rst.rs1code", {5'd0, f1}, {5'd0, `FORWARD_NO_COLLISION});
        cmp("rst.rs2code", {5'd0, f2}, {5'd0, `FORWARD_NO_COLLISION});
        cmp("rst.stall", {6'd0, stall_IF, stall_ID}, 8'd0);
        cmp("rst.bubble", {7'd0, bubble_ID_EX}, 8'd0);
        rst = 0;

        // add x5,x1,x2 ; sub x6,x5,x3
        issue(1, 2, 5, 1, 0, 1, 1, "add5", n);
        issue(5, 3, 6, 1, 0, 1, 1, "sub6", n);
        cmp("dist1.stalls", n[7:0], FE ? 8'd0 : 8'd3);
        nop_check("dist1", FE ? `FORWARD_COLLISION_IN_MEM : `FORWARD_NO_COLLISION);

        // two writers of x5, then a reader: youngest (MEM) wins
        issue(1, 1, 5, 1, 0, 1, 1, "w5a", n);
        issue(2, 2, 5, 1, 0, 1, 1, "w5b", n);
        issue(5, 0, 9, 1, 0, 1, 0, "rd5", n);
        cmp("two_wr.stalls", n[7:0], FE ? 8'd0 : 8'd3);
        nop_check("two_wr", FE ? `FORWARD_COLLISION_IN_MEM : `FORWARD_NO_COLLISION);

        // lw x7 ; add x8,x7,x1
        issue(1, 0, 7, 1, 1, 1, 0, "lw7", n);
        issue(7, 1, 8, 1, 0, 1, 1, "use7", n);
        cmp("lduse.stalls", n[7:0], FE ? 8'd1 : 8'd3);
        nop_check("lduse", FE ? `FORWARD_COLLISION_IN_WB : `FORWARD_NO_COLLISION);

        // addi x0,x0,1 ; reader of x0
        issue(0, 0, 0, 1, 0, 1, 0, "wx0", n);
        issue(0, 0, 10, 1, 0, 1, 1, "rx0", n);
        cmp("x0.stalls", n[7:0], 8'd0);
        nop_check("x0", `FORWARD_NO_COLLISION);

        // load-use coinciding with flush: bubble only
        issue(1, 0, 7, 1, 1, 1, 0, "lw7f", n);
        set_id(7, 0, 8, 1, 0, 1, 0);
        flush_ID_EX = 1;
        #1;
        cmp("flush.bubble", {7'd0, bubble_ID_EX}, 8'd1);
        cmp("flush.stall_IF", {7'd0, stall_IF}, 8'd0);
        cmp("flush.stall_ID", {7'd0, stall_ID}, 8'd0);
        chk("flush");
        tick();
        flush_ID_EX = 0;
        issue(7, 0, 8, 1, 0, 1, 0, "postflush", n);

        // freeze a live forward for 3 cycles
        issue(1, 2, 5, 1, 0, 1, 1, "hadd", n);
        issue(5, 5, 6, 1, 0, 1, 1, "hsub", n);
        set_id(0, 0, 0, 0, 0, 0, 0);
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp("hold.rs1code", {5'd0, f1}, FE ? {5'd0, `FORWARD_COLLISION_IN_MEM} : {5'd0, `FORWARD_NO_COLLISION});
            cmp("hold.rs2code", {5'd0, f2}, FE ? {5'd0, `FORWARD_COLLISION_IN_MEM} : {5'd0, `FORWARD_NO_COLLISION});
            chk("hold");
            tick();
        end
        hold = 0;

        // asynchronous reset while a stall is pending
        issue(1, 0, 7, 1, 1, 1, 0, "lwr", n);
        set_id(7, 0, 8, 1, 0, 1, 0);
        #1;
        chk("prerst");
        rst = 1;
        #1;
        clear_model();
        cmp("arst.stall", {6'd0, stall_IF, stall_ID}, 8'd0);
        cmp("arst.bubble", {7'd0, bubble_ID_EX}, 8'd0);
        chk("arst");
        tick();
        rst = 0;

        // random traffic on a small register set so hazards are frequent
        for (int c = 0; c < 400; c++) begin
            logic we;
            we = 1'($urandom_range(0, 1));
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   we, we & 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            flush_ID_EX = ($urandom_range(0, 7) == 0);
            hold        = ($urandom_range(0, 5) == 0);
            #1;
            chk("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
